// File: rtl/scpu_pkg.sv
// Shared definitions for the sequencing control unit: opcodes, state encoding,
// control-vector bit positions and the decoded instruction classes.
package scpu_pkg;

    localparam logic [4:0] OP_LDI = 5'd0;
    localparam logic [4:0] OP_OUT = 5'd1;
    localparam logic [4:0] OP_JMP = 5'd2;
    localparam logic [4:0] OP_NOP = 5'd3;
    localparam logic [4:0] OP_HLT = 5'd31;

    localparam logic [2:0] ST_RESET  = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC0  = 3'd3;
    localparam logic [2:0] ST_EXEC1  = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    // Bits 0..4 and 6..10 map straight onto the scalar output ports.
    localparam int CTRL_W    = 15;
    localparam int C_MEM_CE  = 0;
    localparam int C_MEM_OE  = 1;
    localparam int C_MEM_R   = 2;
    localparam int C_MEM_W   = 3;
    localparam int C_MEM_RST = 4;
    localparam int C_PC_INC  = 5;
    localparam int C_PC_R    = 6;
    localparam int C_PC_W    = 7;
    localparam int C_PC_RST  = 8;
    localparam int C_HALTED  = 9;
    localparam int C_ILLEGAL = 10;
    localparam int C_INST_R  = 11;
    localparam int C_INST_W  = 12;
    localparam int C_WSEL    = 13;
    localparam int C_RSEL    = 14;

    typedef enum logic [2:0] {
        CLS_NOP = 3'd0,
        CLS_LDI = 3'd1,
        CLS_OUT = 3'd2,
        CLS_JMP = 3'd3,
        CLS_HLT = 3'd4,
        CLS_ILL = 3'd5
    } inst_class_e;

    function automatic logic [CTRL_W-1:0] cbit(input int pos);
        logic [CTRL_W-1:0] one;
        one = {{(CTRL_W-1){1'b0}}, 1'b1};
        return one << pos;
    endfunction

endpackage

// File: rtl/seq_control_unit_decoder.sv
// Combinational instruction decoder: opcode to instruction class, register
// field to a one-hot register select.
module cu_decoder
    import scpu_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int RW    = 3
) (
    input  logic [4:0]       opcode,
    input  logic [RW-1:0]    reg_idx,
    output inst_class_e      cls,
    output logic [NREGS-1:0] reg_sel
);

    // Classify the opcode; anything undefined is reported as illegal.
    always_comb begin
        cls = CLS_ILL;
        case (opcode)
            OP_LDI:  cls = CLS_LDI;
            OP_OUT:  cls = CLS_OUT;
            OP_JMP:  cls = CLS_JMP;
            OP_NOP:  cls = CLS_NOP;
            OP_HLT:  cls = CLS_HLT;
            default: cls = CLS_ILL;
        endcase
    end

    assign reg_sel = {{(NREGS-1){1'b0}}, 1'b1} << reg_idx;

endmodule

// File: rtl/seq_control_unit.sv
// Instruction sequencer: state and control vector advance on the falling edge,
// the instruction register captures the bus on the rising edge.
module seq_control_unit
    import scpu_pkg::*;
#(
    parameter int DW    = 8,
    parameter int NREGS = 8,
    parameter int RSTW  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    data_bus_in,
    output logic [DW-1:0]    data_bus_out,
    input  logic             mem_ready,
    output logic [NREGS-1:0] regs_wsel,
    output logic [NREGS-1:0] regs_rsel,
    output logic             mem_ce,
    output logic             mem_oe,
    output logic             mem_r,
    output logic             mem_w,
    output logic             mem_rst,
    output logic             pc_inc,
    output logic             pc_r,
    output logic             pc_w,
    output logic             pc_rst,
    output logic             halted,
    output logic             illegal
);

    localparam int RW = $clog2(NREGS);
    localparam int CW = $clog2(RSTW + 1) + 1;

    logic [2:0]        state_r;
    logic [2:0]        state_s;
    logic [CW-1:0]     rcnt_r;
    logic [CW-1:0]     rcnt_s;
    logic [CTRL_W-1:0] ctrl_r;
    logic [CTRL_W-1:0] ctrl_s;
    logic [DW-1:0]     ireg_r;
    inst_class_e       cls_s;
    logic [NREGS-1:0]  sel_s;

    function automatic logic [CTRL_W-1:0] ctrl_for(input logic [2:0] st, input inst_class_e cls);
        logic [CTRL_W-1:0] c;
        c = '0;
        case (st)
            ST_RESET:  c = cbit(C_PC_RST) | cbit(C_MEM_RST);
            ST_FETCH:  c = cbit(C_MEM_CE) | cbit(C_MEM_R) | cbit(C_PC_R);
            ST_DECODE: c = cbit(C_MEM_CE) | cbit(C_MEM_OE) | cbit(C_INST_W) | cbit(C_PC_INC);
            ST_EXEC0: begin
                case (cls)
                    CLS_LDI, CLS_JMP: c = cbit(C_MEM_CE) | cbit(C_MEM_R) | cbit(C_PC_R);
                    CLS_OUT:          c = cbit(C_RSEL);
                    CLS_ILL:          c = cbit(C_ILLEGAL);
                    default:          c = '0;
                endcase
            end
            ST_EXEC1: begin
                case (cls)
                    CLS_LDI: c = cbit(C_MEM_CE) | cbit(C_MEM_OE) | cbit(C_PC_INC) | cbit(C_WSEL);
                    CLS_JMP: c = cbit(C_MEM_CE) | cbit(C_MEM_OE) | cbit(C_PC_W);
                    default: c = '0;
                endcase
            end
            ST_HALT:   c = cbit(C_HALTED);
            default:   c = '0;
        endcase
        return c;
    endfunction

    cu_decoder #(
        .NREGS(NREGS),
        .RW   (RW)
    ) u_decoder (
        .opcode (ireg_r[DW-1:DW-5]),
        .reg_idx(ireg_r[RW-1:0]),
        .cls    (cls_s),
        .reg_sel(sel_s)
    );

    // Next-state logic; DECODE and EXEC1 hold while memory data is not ready.
    always_comb begin
        state_s = state_r;
        rcnt_s  = rcnt_r;
        case (state_r)
            ST_RESET: begin
                if (rcnt_r == CW'(RSTW)) begin
                    state_s = ST_FETCH;
                end else begin
                    rcnt_s = rcnt_r + 1'b1;
                end
            end
            ST_FETCH:  state_s = ST_DECODE;
            ST_DECODE: begin
                if (mem_ready) begin
                    state_s = ST_EXEC0;
                end else begin
                    state_s = ST_DECODE;
                end
            end
            ST_EXEC0: begin
                case (cls_s)
                    CLS_LDI, CLS_JMP: state_s = ST_EXEC1;
                    CLS_HLT:          state_s = ST_HALT;
                    default:          state_s = ST_FETCH;
                endcase
            end
            ST_EXEC1: begin
                if (mem_ready) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_EXEC1;
                end
            end
            ST_HALT:   state_s = ST_HALT;
            default: begin
                state_s = ST_RESET;
                rcnt_s  = '0;
            end
        endcase
        ctrl_s = ctrl_for(state_s, cls_s);
    end

    // The control vector is registered together with the state it belongs to.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RESET;
            rcnt_r  <= '0;
            ctrl_r  <= '0;
        end else begin
            state_r <= state_s;
            rcnt_r  <= rcnt_s;
            ctrl_r  <= ctrl_s;
        end
    end

    // Instruction register captures the bus mid-DECODE once memory is ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ireg_r <= '0;
        end else if (ctrl_r[C_INST_W] && mem_ready) begin
            ireg_r <= data_bus_in;
        end else begin
            ireg_r <= ireg_r;
        end
    end

    assign {illegal, halted, pc_rst, pc_w, pc_r, mem_rst, mem_w, mem_r, mem_oe, mem_ce} =
           {ctrl_r[C_ILLEGAL:C_PC_R], ctrl_r[C_MEM_RST:C_MEM_CE]};
    // A stalled cycle must not advance the program counter.
    assign pc_inc       = ctrl_r[C_PC_INC] & mem_ready;
    assign regs_wsel    = ctrl_r[C_WSEL] ? sel_s : {NREGS{1'b0}};
    assign regs_rsel    = ctrl_r[C_RSEL] ? sel_s : {NREGS{1'b0}};
    assign data_bus_out = ctrl_r[C_INST_R] ? ireg_r : {DW{1'bz}};

endmodule

// File: doc/seq_control_unit.md
SEQ_CONTROL_UNIT -- requirements
Module: seq_control_unit

Interface
REQ-001 Parameter DW, default 8, data bus and instruction width.
REQ-002 Parameter NREGS, default 8, register-file entries; must be a power of 2, at most 2^(DW-5).
REQ-003 Parameter RSTW, default 2, cycles the RESET state holds pc_rst/mem_rst; must be 1 or more.
REQ-004 clk  in  1  single clock; state register updates on negedge, instruction register on posedge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 data_bus_in  in  DW  shared bus read by the control unit.
REQ-007 data_bus_out  out  DW  instruction register when inst_r=1, else high-Z.
REQ-008 mem_ready  in  1  memory handshake; 1 = addressed data valid on data_bus_in.
REQ-009 regs_wsel  out  NREGS  one-hot register write strobe.
REQ-010 regs_rsel  out  NREGS  one-hot register read (bus drive) strobe.
REQ-011 mem_ce, mem_oe, mem_r, mem_w, mem_rst  out  1 each  memory controls.
REQ-012 pc_inc, pc_r, pc_w, pc_rst  out  1 each  program-counter controls.
REQ-013 halted  out  1  high while in HALT.
REQ-014 illegal  out  1  one-cycle pulse on an undefined opcode.

Function
REQ-015 Instruction fields: opcode = inst[DW-1:DW-5]; reg = inst[log2(NREGS)-1:0].
REQ-016 Opcodes: 0 LDI r,imm; 1 OUT r (regs_rsel[r] for one cycle); 2 JMP imm (pc_w from bus); 3 NOP; 31 HLT; all others are illegal and execute as NOP.
REQ-017 States: RESET, FETCH, DECODE, EXEC0, EXEC1, HALT; each transition takes one negedge.
REQ-018 RESET: pc_rst=mem_rst=1 for RSTW cycles, then FETCH.
REQ-019 FETCH: mem_ce|mem_r|pc_r; then DECODE.
REQ-020 DECODE: mem_ce|mem_oe|inst_w|pc_inc; inst latches at the next posedge; then EXEC0.
REQ-021 DECODE stalls while mem_ready=0: all outputs are held, pc_inc is suppressed, and inst is not written.
REQ-022 EXEC0, LDI/JMP: mem_ce|mem_r|pc_r; then EXEC1.
REQ-023 EXEC0, OUT/NOP/illegal: one control cycle, then FETCH.
REQ-024 EXEC0, HLT: to HALT.
REQ-025 EXEC1, LDI: mem_ce|mem_oe|pc_inc|regs_wsel[r].
REQ-026 EXEC1, JMP: mem_ce|mem_oe|pc_w, no pc_inc.
REQ-027 EXEC1 stalls on mem_ready=0 exactly as DECODE does; it then goes to FETCH.
REQ-028 Latency with no stalls: LDI and JMP take 4 cycles; OUT, NOP and illegal take 3 cycles.
REQ-029 regs_wsel and regs_rsel are always one-hot or zero; they are never both nonzero in the same cycle.
REQ-030 mem_w stays 0 in this generation; the port is reserved.
REQ-031 HALT: all strobes are 0 and halted=1; only rst exits HALT.
REQ-032 An out-of-range register index cannot occur, because the field width equals log2(NREGS).

Reset
REQ-033 rst=1 forces state=RESET, inst=0 and all strobes 0 immediately; halted=0 and illegal=0.
REQ-034 rst asserted mid-instruction abandons that instruction: no register write and no pc_w occur.
REQ-035 After rst deasserts, the first FETCH occurs RSTW+1 negedges later.

Structure
REQ-036 Shared package scpu_pkg holds the opcode constants, the state encoding, and the control-bit positions with a single control-vector width.
REQ-037 Control outputs are driven from one registered control vector, as a concatenation assign.
REQ-038 The sub-module cu_decoder (combinational) maps opcode to instruction class and one-hot register select; the sequencer stays in the top module.

Verification
REQ-039 Memory {0x02,0x5A} at 0, mem_ready=1 -> at the LDI EXEC1 cycle regs_wsel=8'b0000_0100, bus=0x5A; pc_inc pulses twice; 4 cycles.
REQ-040 {0x10,0x07} (JMP 7) -> pc_w=1 with bus=0x07; next FETCH pc_r; pc_inc pulses exactly once.
REQ-041 Illegal opcode 0x28 -> illegal pulses one cycle, no strobes except fetch/decode, next FETCH after 3 cycles.
REQ-042 mem_ready low for 3 cycles during DECODE -> outputs frozen 3 cycles, single pc_inc, correct inst latched.
REQ-043 rst asserted in LDI EXEC0 -> regs_wsel never asserts; pc_rst high RSTW cycles; refetch from 0.
REQ-044 HLT (0xF8) -> halted=1 and all strobes 0 for 20 cycles despite mem_ready toggling.
